res_station: RTL and testbench
==============================

RES_STATION -- requirements
Module: res_station

Interface
REQ-001 SHALL have parameters (name, default, meaning):
- RS_DEPTH, 8, number of entries; power of two, at least 2.
- TAG_WIDTH, PHY_RF_ADDR_WIDTH, physical-register tag width.
- ROB_WIDTH, width of rob_addr_t, ROB index width.
- PAYLOAD_WIDTH, UOP_WIDTH, opaque operation payload width.

REQ-002 SHALL have ports (name, direction, width, meaning):
- clk, in, 1, the single clock.
- rst, in, 1, asynchronous, active-high reset.
- flush, in, 1, synchronous clear on branch mispredict.
- res_st_wr_en, in, 1, entry write strobe.
- res_st_wr_addr, in, log2(RS_DEPTH), entry index to write.
- wr_payload, in, PAYLOAD_WIDTH, operation payload.
- wr_rob_idx, in, ROB_WIDTH, ROB index of the operation.
- wr_rs1_rdy, in, 1, rs1 value valid.
- wr_rs1_tag, in, TAG_WIDTH, rs1 physical tag.
- wr_rs1_val, in, 32, rs1 value.
- wr_rs2_rdy, in, 1, rs2 value valid.
- wr_rs2_tag, in, TAG_WIDTH, rs2 physical tag.
- wr_rs2_val, in, 32, rs2 value.
- cdb_valid, in, 1, result broadcast valid.
- cdb_tag, in, TAG_WIDTH, broadcast tag.
- cdb_data, in, 32, broadcast value.
- free_addr, out, log2(RS_DEPTH), lowest-index free entry.
- full, out, 1, no free entry.
- count, out, log2(RS_DEPTH)+1, occupied entries.
- wr_err, out, 1, registered pulse: write was dropped.
- issue_valid, out, 1, an entry is ready to issue.
- issue_ready, in, 1, execution unit accepts.
- issue_payload, out, PAYLOAD_WIDTH, payload of the issued entry.
- issue_rob_idx, out, ROB_WIDTH, ROB index of the issued entry.
- issue_rs1_val, out, 32, rs1 operand of the issued entry.
- issue_rs2_val, out, 32, rs2 operand of the issued entry.

Function
REQ-003 SHALL hold per entry: valid, payload, rob_idx, and for each operand rdy, tag and val.

REQ-004 SHALL, on res_st_wr_en with the addressed entry invalid, load all wr_* fields and set valid at the next edge.

REQ-005 SHALL, on res_st_wr_en with the addressed entry valid and not being issued that cycle, drop the write, leave the entry unchanged and assert wr_err for one cycle.

REQ-006 SHALL, each cycle with cdb_valid, set rdy and load val := cdb_data for every valid entry operand whose rdy=0 and whose tag equals cdb_tag.

REQ-007 SHALL apply the CDB to an operand being written in the same cycle when wr_rsX_rdy=0 and wr_rsX_tag equals cdb_tag, so that the entry lands ready with cdb_data.

REQ-008 SHALL assert issue_valid combinationally when any valid entry has both rdy=1, and SHALL select the lowest-index such entry.

REQ-009 SHALL drive the issue_* data outputs from the selected entry, and SHALL drive them to 0 when issue_valid=0.

REQ-010 SHALL clear the selected entry's valid at the edge where issue_valid and issue_ready are both 1.

REQ-011 SHALL keep the same entry selected and its outputs stable while issue_ready=0, unless a lower-index entry becomes ready.

REQ-012 SHALL NOT issue an operand that becomes ready via the CDB in cycle N before cycle N+1; there is no CDB-to-issue combinational bypass.

REQ-013 SHALL, when an issue and a write target the same entry in the same cycle, free the entry and accept the write, with the entry valid holding the new contents after the edge.

REQ-014 SHALL derive free_addr (lowest invalid index, 0 when full), full and count from the registered valid bits only.

REQ-015 SHALL, on flush, clear all valid bits at the next edge, ignore a simultaneous write, and suppress the handshake for that cycle with no entry freed twice.

REQ-016 SHALL treat count as the number of valid bits, ranging over 0..RS_DEPTH.

Reset
REQ-017 SHALL, on rst asserted, asynchronously clear all valid bits, rdy bits and wr_err.

REQ-018 SHALL, in reset, hold full=0, count=0, free_addr=0 and issue_valid=0, with all issue_* data outputs at 0.

REQ-019 SHALL ignore all inputs while rst is high; the first write is accepted at the first edge after rst deasserts.

Verification
REQ-020 SHALL be verified with these directed scenarios:
- V1: write entry 0 with both rdy=1, rs1=5, rs2=7, issue_ready=1 -> issue_valid=1 the next cycle with issue_rs1_val=5 and issue_rs2_val=7; count goes 1 then 0.
- V2: write entry 2 with rs1 rdy=0, tag=9; two cycles later cdb_valid, tag 9, data 0xABCD -> issue_valid one cycle later with issue_rs1_val=0xABCD.
- V3: write with rs2 rdy=0, tag=3, while cdb_valid carries tag 3, data 0x11 in the same cycle -> the entry is ready the next cycle with rs2=0x11.
- V4: fill all 8 entries -> full=1, count=8; a write to valid entry 4 -> wr_err pulses and entry 4 is unchanged.
- V5: entries 1 and 5 ready with issue_ready=0 for 3 cycles -> entry 1 held stable; then ready=1 -> entry 1 issues, then entry 5 issues.
- V6: 5 entries valid, then flush together with a write -> count=0 and free_addr=0 the next cycle; an rst pulse mid-operation clears the block asynchronously.

Source files
------------

// File: rtl/res_station.sv
// Reservation station: holds renamed ops until both operands are ready, wakes them from the CDB and issues the lowest ready entry.
// Latency: a write is visible at the next edge. A CDB wakeup makes the entry issuable one cycle later. Issue select is combinational from registered state.
// Backpressure: issue_valid/issue_ready handshake. The selected entry and its outputs hold while issue_ready=0. A write to an occupied slot is dropped and flagged on wr_err.
//
// Ports:
//   clk, rst (async, active-high), flush (sync clear of all entries)
//   res_st_wr_en/res_st_wr_addr/wr_* : entry write with both operand descriptors
//   cdb_valid/cdb_tag/cdb_data        : result broadcast used to wake waiting operands
//   free_addr/full/count              : occupancy status, derived from registered valid bits
//   wr_err                            : registered one-cycle pulse when a write was dropped
//   issue_valid/issue_ready/issue_*   : issue handshake and the selected entry's contents
module res_station #(
  parameter int RS_DEPTH      = 8,
  parameter int TAG_WIDTH     = 6,   // physical register file address width
  parameter int ROB_WIDTH     = 5,   // ROB index width
  parameter int PAYLOAD_WIDTH = 16,  // opaque micro-op width
  localparam int AW           = $clog2(RS_DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     res_st_wr_en,
  input  logic [AW-1:0]            res_st_wr_addr,
  input  logic [PAYLOAD_WIDTH-1:0] wr_payload,
  input  logic [ROB_WIDTH-1:0]     wr_rob_idx,
  input  logic                     wr_rs1_rdy,
  input  logic [TAG_WIDTH-1:0]     wr_rs1_tag,
  input  logic [31:0]              wr_rs1_val,
  input  logic                     wr_rs2_rdy,
  input  logic [TAG_WIDTH-1:0]     wr_rs2_tag,
  input  logic [31:0]              wr_rs2_val,
  input  logic                     cdb_valid,
  input  logic [TAG_WIDTH-1:0]     cdb_tag,
  input  logic [31:0]              cdb_data,
  output logic [AW-1:0]            free_addr,
  output logic                     full,
  output logic [AW:0]              count,
  output logic                     wr_err,
  output logic                     issue_valid,
  input  logic                     issue_ready,
  output logic [PAYLOAD_WIDTH-1:0] issue_payload,
  output logic [ROB_WIDTH-1:0]     issue_rob_idx,
  output logic [31:0]              issue_rs1_val,
  output logic [31:0]              issue_rs2_val
);

  typedef struct packed {
    logic [PAYLOAD_WIDTH-1:0] payload;
    logic [ROB_WIDTH-1:0]     rob_idx;
    logic [TAG_WIDTH-1:0]     rs1_tag;
    logic [31:0]              rs1_val;
    logic [TAG_WIDTH-1:0]     rs2_tag;
    logic [31:0]              rs2_val;
  } entry_t;

  entry_t              ent [RS_DEPTH];
  logic [RS_DEPTH-1:0] valid;
  logic [RS_DEPTH-1:0] rs1_rdy;
  logic [RS_DEPTH-1:0] rs2_rdy;

  logic [RS_DEPTH-1:0] ready_vec;
  logic [AW-1:0]       sel;
  logic                fire;
  logic                slot_free;
  logic                wr_acc;
  logic                wr_drop;
  logic                wr_rs1_hit;
  logic                wr_rs2_hit;
  entry_t              wr_ent;

  // Issue candidates come from registered rdy bits only, so a CDB wakeup
  // never reaches the issue port in the same cycle.
  assign ready_vec = valid & rs1_rdy & rs2_rdy;

  // Lowest-index ready entry: scanning downward lets the lowest hit win.
  always_comb begin
    issue_valid = 1'b0;
    sel         = '0;
    for (int i = RS_DEPTH - 1; i >= 0; i--) begin
      if (ready_vec[i]) begin
        issue_valid = 1'b1;
        sel         = AW'(i);
      end
    end
  end

  always_comb begin
    issue_payload = '0;
    issue_rob_idx = '0;
    issue_rs1_val = '0;
    issue_rs2_val = '0;
    if (issue_valid) begin
      issue_payload = ent[sel].payload;
      issue_rob_idx = ent[sel].rob_idx;
      issue_rs1_val = ent[sel].rs1_val;
      issue_rs2_val = ent[sel].rs2_val;
    end
  end

  // Occupancy status from the registered valid bits.
  always_comb begin
    free_addr = '0;
    full      = &valid;
    count     = '0;
    for (int i = RS_DEPTH - 1; i >= 0; i--) begin
      if (!valid[i]) begin
        free_addr = AW'(i);
      end
    end
    for (int i = 0; i < RS_DEPTH; i++) begin
      count = count + {{AW{1'b0}}, valid[i]};
    end
  end

  // Flush kills the handshake so the entry is not freed by both flush and issue.
  assign fire = issue_valid & issue_ready & ~flush;

  // A slot that is being issued this cycle may be overwritten.
  assign slot_free = ~valid[res_st_wr_addr] | (fire & (sel == res_st_wr_addr));
  assign wr_acc    = res_st_wr_en & ~flush & slot_free;
  assign wr_drop   = res_st_wr_en & ~flush & ~slot_free;

  // CDB result arriving alongside the write lands the operand already ready.
  assign wr_rs1_hit = cdb_valid & ~wr_rs1_rdy & (wr_rs1_tag == cdb_tag);
  assign wr_rs2_hit = cdb_valid & ~wr_rs2_rdy & (wr_rs2_tag == cdb_tag);

  always_comb begin
    wr_ent.payload = wr_payload;
    wr_ent.rob_idx = wr_rob_idx;
    wr_ent.rs1_tag = wr_rs1_tag;
    wr_ent.rs1_val = wr_rs1_hit ? cdb_data : wr_rs1_val;
    wr_ent.rs2_tag = wr_rs2_tag;
    wr_ent.rs2_val = wr_rs2_hit ? cdb_data : wr_rs2_val;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid   <= '0;
      rs1_rdy <= '0;
      rs2_rdy <= '0;
      wr_err  <= 1'b0;
      for (int i = 0; i < RS_DEPTH; i++) begin
        ent[i] <= '0;
      end
    end else begin
      wr_err <= wr_drop;
      if (flush) begin
        valid <= '0;
      end else begin
        // Wake waiting operands of occupied entries.
        if (cdb_valid) begin
          for (int i = 0; i < RS_DEPTH; i++) begin
            if (valid[i] && !rs1_rdy[i] && ent[i].rs1_tag == cdb_tag) begin
              rs1_rdy[i]     <= 1'b1;
              ent[i].rs1_val <= cdb_data;
            end
            if (valid[i] && !rs2_rdy[i] && ent[i].rs2_tag == cdb_tag) begin
              rs2_rdy[i]     <= 1'b1;
              ent[i].rs2_val <= cdb_data;
            end
          end
        end
        if (fire) begin
          valid[sel] <= 1'b0;
        end
        // Placed after the issue clear so a same-slot write wins.
        if (wr_acc) begin
          valid[res_st_wr_addr]   <= 1'b1;
          rs1_rdy[res_st_wr_addr] <= wr_rs1_rdy | wr_rs1_hit;
          rs2_rdy[res_st_wr_addr] <= wr_rs2_rdy | wr_rs2_hit;
          ent[res_st_wr_addr]     <= wr_ent;
        end
      end
    end
  end

endmodule

// File: tb/tb_res_station.sv
module tb_res_station;

  localparam int PW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          res_st_wr_en;
  logic [2:0]    res_st_wr_addr;
  logic [PW-1:0] wr_payload;
  logic [4:0]    wr_rob_idx;
  logic          wr_rs1_rdy;
  logic [5:0]    wr_rs1_tag;
  logic [31:0]   wr_rs1_val;
  logic          wr_rs2_rdy;
  logic [5:0]    wr_rs2_tag;
  logic [31:0]   wr_rs2_val;
  logic          cdb_valid;
  logic [5:0]    cdb_tag;
  logic [31:0]   cdb_data;
  logic [2:0]    free_addr;
  logic          full;
  logic [3:0]    count;
  logic          wr_err;
  logic          issue_valid;
  logic          issue_ready;
  logic [PW-1:0] issue_payload;
  logic [4:0]    issue_rob_idx;
  logic [31:0]   issue_rs1_val;
  logic [31:0]   issue_rs2_val;

  int n_pass  = 0;
  int n_total = 0;

  res_station #(
    .RS_DEPTH(8), .TAG_WIDTH(6), .ROB_WIDTH(5), .PAYLOAD_WIDTH(PW)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .res_st_wr_en(res_st_wr_en), .res_st_wr_addr(res_st_wr_addr),
    .wr_payload(wr_payload), .wr_rob_idx(wr_rob_idx),
    .wr_rs1_rdy(wr_rs1_rdy), .wr_rs1_tag(wr_rs1_tag), .wr_rs1_val(wr_rs1_val),
    .wr_rs2_rdy(wr_rs2_rdy), .wr_rs2_tag(wr_rs2_tag), .wr_rs2_val(wr_rs2_val),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .free_addr(free_addr), .full(full), .count(count), .wr_err(wr_err),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_payload(issue_payload), .issue_rob_idx(issue_rob_idx),
    .issue_rs1_val(issue_rs1_val), .issue_rs2_val(issue_rs2_val)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_wr(input logic [2:0] a, input logic [PW-1:0] pl, input logic [4:0] rob,
                          input logic r1, input logic [5:0] t1, input logic [31:0] v1,
                          input logic r2, input logic [5:0] t2, input logic [31:0] v2);
    res_st_wr_en   = 1'b1;
    res_st_wr_addr = a;
    wr_payload     = pl;
    wr_rob_idx     = rob;
    wr_rs1_rdy     = r1;
    wr_rs1_tag     = t1;
    wr_rs1_val     = v1;
    wr_rs2_rdy     = r2;
    wr_rs2_tag     = t2;
    wr_rs2_val     = v2;
  endtask

  task automatic idle_wr();
    res_st_wr_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0; issue_ready = 1'b1;
    // A write held during reset must be ignored.
    drive_wr(3'd0, 16'h7777, 5'd1, 1'b1, 6'd0, 32'd1, 1'b1, 6'd0, 32'd2);
    repeat (2) @(posedge clk);
    #1;
    n_total++; if (count !== 4'd0) $display("FAIL reset_count act=%0d exp=0", count); else n_pass++;
    n_total++; if (full !== 1'b0) $display("FAIL reset_full act=%b exp=0", full); else n_pass++;
    n_total++; if (free_addr !== 3'd0) $display("FAIL reset_free_addr act=%0d exp=0", free_addr); else n_pass++;
    n_total++; if (issue_valid !== 1'b0) $display("FAIL reset_issue_valid act=%b exp=0", issue_valid); else n_pass++;
    n_total++; if (issue_rs1_val !== 32'd0 || issue_payload !== 16'd0) $display("FAIL reset_issue_data act=%h/%h exp=0/0", issue_rs1_val, issue_payload); else n_pass++;
    n_total++; if (wr_err !== 1'b0) $display("FAIL reset_wr_err act=%b exp=0", wr_err); else n_pass++;
    idle_wr();
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic_issue();
    issue_ready = 1'b1;
    drive_wr(3'd0, 16'h1234, 5'd3, 1'b1, 6'd0, 32'd5, 1'b1, 6'd0, 32'd7);
    step();
    idle_wr();
    n_total++; if (issue_valid !== 1'b1) $display("FAIL v1_issue_valid act=%b exp=1", issue_valid); else n_pass++;
    n_total++; if (issue_rs1_val !== 32'd5) $display("FAIL v1_rs1 act=%0d exp=5", issue_rs1_val); else n_pass++;
    n_total++; if (issue_rs2_val !== 32'd7) $display("FAIL v1_rs2 act=%0d exp=7", issue_rs2_val); else n_pass++;
    n_total++; if (issue_payload !== 16'h1234 || issue_rob_idx !== 5'd3) $display("FAIL v1_payload_rob act=%h/%0d exp=1234/3", issue_payload, issue_rob_idx); else n_pass++;
    n_total++; if (count !== 4'd1) $display("FAIL v1_count1 act=%0d exp=1", count); else n_pass++;
    n_total++; if (free_addr !== 3'd1) $display("FAIL v1_free_addr act=%0d exp=1", free_addr); else n_pass++;
    step();
    n_total++; if (count !== 4'd0) $display("FAIL v1_count0 act=%0d exp=0", count); else n_pass++;
    n_total++; if (issue_valid !== 1'b0 || issue_rs1_val !== 32'd0) $display("FAIL v1_idle act=%b/%h exp=0/0", issue_valid, issue_rs1_val); else n_pass++;
  endtask

  task automatic test_cdb_wakeup();
    issue_ready = 1'b1;
    drive_wr(3'd2, 16'h0202, 5'd4, 1'b0, 6'd9, 32'd0, 1'b1, 6'd0, 32'd2);
    step();
    idle_wr();
    n_total++; if (issue_valid !== 1'b0) $display("FAIL v2_wait act=%b exp=0", issue_valid); else n_pass++;
    n_total++; if (count !== 4'd1 || free_addr !== 3'd0) $display("FAIL v2_occupancy act=%0d/%0d exp=1/0", count, free_addr); else n_pass++;
    cdb_valid = 1'b1; cdb_tag = 6'd8; cdb_data = 32'hFFFF;
    step();
    n_total++; if (issue_valid !== 1'b0) $display("FAIL v2_wrong_tag act=%b exp=0", issue_valid); else n_pass++;
    cdb_tag = 6'd9; cdb_data = 32'hABCD;
    #1;
    n_total++; if (issue_valid !== 1'b0) $display("FAIL v2_no_bypass act=%b exp=0", issue_valid); else n_pass++;
    step();
    cdb_valid = 1'b0;
    n_total++; if (issue_valid !== 1'b1) $display("FAIL v2_woken act=%b exp=1", issue_valid); else n_pass++;
    n_total++; if (issue_rs1_val !== 32'hABCD || issue_rs2_val !== 32'd2) $display("FAIL v2_vals act=%h/%h exp=abcd/2", issue_rs1_val, issue_rs2_val); else n_pass++;
    n_total++; if (issue_rob_idx !== 5'd4) $display("FAIL v2_rob act=%0d exp=4", issue_rob_idx); else n_pass++;
    step();
    n_total++; if (count !== 4'd0) $display("FAIL v2_drain act=%0d exp=0", count); else n_pass++;
  endtask

  task automatic test_cdb_same_cycle();
    issue_ready = 1'b1;
    drive_wr(3'd0, 16'h0303, 5'd5, 1'b1, 6'd0, 32'd4, 1'b0, 6'd3, 32'd0);
    cdb_valid = 1'b1; cdb_tag = 6'd3; cdb_data = 32'h11;
    step();
    idle_wr();
    cdb_valid = 1'b0;
    n_total++; if (issue_valid !== 1'b1) $display("FAIL v3_ready act=%b exp=1", issue_valid); else n_pass++;
    n_total++; if (issue_rs2_val !== 32'h11 || issue_rs1_val !== 32'd4) $display("FAIL v3_vals act=%h/%h exp=4/11", issue_rs1_val, issue_rs2_val); else n_pass++;
    step();
    n_total++; if (count !== 4'd0) $display("FAIL v3_drain act=%0d exp=0", count); else n_pass++;
  endtask

  task automatic test_full_and_wr_err();
    issue_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      n_total++; if (free_addr !== 3'(i)) $display("FAIL v4_free_addr_%0d act=%0d exp=%0d", i, free_addr, i); else n_pass++;
      drive_wr(3'(i), PW'(256 + i), 5'(i), 1'b0, 6'd20, 32'd0, 1'b1, 6'd0, 32'(512 + i));
      step();
    end
    idle_wr();
    n_total++; if (full !== 1'b1 || count !== 4'd8) $display("FAIL v4_full act=%b/%0d exp=1/8", full, count); else n_pass++;
    n_total++; if (free_addr !== 3'd0 || issue_valid !== 1'b0) $display("FAIL v4_full_status act=%0d/%b exp=0/0", free_addr, issue_valid); else n_pass++;
    drive_wr(3'd4, 16'hDEAD, 5'd31, 1'b1, 6'd0, 32'hBAD, 1'b1, 6'd0, 32'hBAD);
    step();
    idle_wr();
    n_total++; if (wr_err !== 1'b1 || count !== 4'd8) $display("FAIL v4_wr_err act=%b/%0d exp=1/8", wr_err, count); else n_pass++;
    step();
    n_total++; if (wr_err !== 1'b0) $display("FAIL v4_wr_err_pulse act=%b exp=0", wr_err); else n_pass++;
    cdb_valid = 1'b1; cdb_tag = 6'd20; cdb_data = 32'h55;
    step();
    cdb_valid = 1'b0;
    issue_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      n_total++;
      if (issue_valid !== 1'b1 || issue_payload !== PW'(256 + i) || issue_rs1_val !== 32'h55 || issue_rs2_val !== 32'(512 + i))
        $display("FAIL v4_issue_%0d act=%b/%h/%h/%h exp=1/%h/55/%h", i, issue_valid, issue_payload, issue_rs1_val, issue_rs2_val, PW'(256 + i), 32'(512 + i));
      else n_pass++;
      step();
    end
    n_total++; if (count !== 4'd0 || full !== 1'b0) $display("FAIL v4_drain act=%0d/%b exp=0/0", count, full); else n_pass++;
    issue_ready = 1'b0;
  endtask

  task automatic test_hold();
    issue_ready = 1'b0;
    drive_wr(3'd5, 16'h00A5, 5'd7, 1'b1, 6'd0, 32'h55, 1'b1, 6'd0, 32'h56);
    step();
    n_total++; if (issue_payload !== 16'h00A5) $display("FAIL v5_sel5 act=%h exp=00a5", issue_payload); else n_pass++;
    drive_wr(3'd1, 16'h00A1, 5'd8, 1'b1, 6'd0, 32'h11, 1'b1, 6'd0, 32'h12);
    step();
    idle_wr();
    for (int c = 0; c < 3; c++) begin
      n_total++;
      if (issue_valid !== 1'b1 || issue_payload !== 16'h00A1 || issue_rs1_val !== 32'h11 || count !== 4'd2)
        $display("FAIL v5_hold_%0d act=%b/%h/%h/%0d exp=1/00a1/11/2", c, issue_valid, issue_payload, issue_rs1_val, count);
      else n_pass++;
      step();
    end
    issue_ready = 1'b1;
    #1;
    n_total++; if (issue_payload !== 16'h00A1) $display("FAIL v5_first act=%h exp=00a1", issue_payload); else n_pass++;
    step();
    n_total++; if (issue_payload !== 16'h00A5 || count !== 4'd1) $display("FAIL v5_second act=%h/%0d exp=00a5/1", issue_payload, count); else n_pass++;
    step();
    n_total++; if (issue_valid !== 1'b0 || count !== 4'd0) $display("FAIL v5_drain act=%b/%0d exp=0/0", issue_valid, count); else n_pass++;
    issue_ready = 1'b0;
  endtask

  task automatic test_issue_write_same_entry();
    issue_ready = 1'b0;
    drive_wr(3'd0, 16'h00B1, 5'd9, 1'b1, 6'd0, 32'd1, 1'b1, 6'd0, 32'd1);
    step();
    issue_ready = 1'b1;
    drive_wr(3'd0, 16'h00B2, 5'd10, 1'b1, 6'd0, 32'd2, 1'b1, 6'd0, 32'd3);
    step();
    idle_wr();
    issue_ready = 1'b0;
    n_total++; if (wr_err !== 1'b0) $display("FAIL same_entry_wr_err act=%b exp=0", wr_err); else n_pass++;
    n_total++; if (issue_payload !== 16'h00B2 || count !== 4'd1) $display("FAIL same_entry_new act=%h/%0d exp=00b2/1", issue_payload, count); else n_pass++;
    issue_ready = 1'b1;
    step();
    issue_ready = 1'b0;
    n_total++; if (count !== 4'd0) $display("FAIL same_entry_drain act=%0d exp=0", count); else n_pass++;
  endtask

  task automatic test_flush_and_async_reset();
    issue_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive_wr(3'(i), PW'(i), 5'(i), 1'b1, 6'd0, 32'(i), 1'b1, 6'd0, 32'(i));
      step();
    end
    idle_wr();
    n_total++; if (count !== 4'd5 || free_addr !== 3'd5) $display("FAIL v6_five act=%0d/%0d exp=5/5", count, free_addr); else n_pass++;
    flush = 1'b1;
    issue_ready = 1'b1;
    drive_wr(3'd6, 16'h0066, 5'd6, 1'b1, 6'd0, 32'd6, 1'b1, 6'd0, 32'd6);
    step();
    flush = 1'b0;
    idle_wr();
    issue_ready = 1'b0;
    n_total++; if (count !== 4'd0 || free_addr !== 3'd0) $display("FAIL v6_flush act=%0d/%0d exp=0/0", count, free_addr); else n_pass++;
    n_total++; if (issue_valid !== 1'b0 || wr_err !== 1'b0) $display("FAIL v6_flush_idle act=%b/%b exp=0/0", issue_valid, wr_err); else n_pass++;
    drive_wr(3'd0, 16'h0070, 5'd1, 1'b1, 6'd0, 32'd1, 1'b1, 6'd0, 32'd1);
    step();
    drive_wr(3'd1, 16'h0071, 5'd2, 1'b1, 6'd0, 32'd1, 1'b1, 6'd0, 32'd1);
    step();
    idle_wr();
    n_total++; if (count !== 4'd2) $display("FAIL v6_pre_rst act=%0d exp=2", count); else n_pass++;
    #3;
    rst = 1'b1;
    #1;
    n_total++; if (count !== 4'd0 || issue_valid !== 1'b0 || issue_payload !== 16'd0) $display("FAIL v6_async_rst act=%0d/%b/%h exp=0/0/0", count, issue_valid, issue_payload); else n_pass++;
    #2;
    rst = 1'b0;
    drive_wr(3'd3, 16'h0073, 5'd3, 1'b1, 6'd0, 32'd9, 1'b1, 6'd0, 32'd9);
    step();
    idle_wr();
    n_total++; if (count !== 4'd1 || free_addr !== 3'd0 || issue_payload !== 16'h0073) $display("FAIL v6_post_rst_write act=%0d/%0d/%h exp=1/0/0073", count, free_addr, issue_payload); else n_pass++;
    issue_ready = 1'b1;
    step();
    issue_ready = 1'b0;
    n_total++; if (count !== 4'd0) $display("FAIL v6_drain act=%0d exp=0", count); else n_pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic_issue();
    test_cdb_wakeup();
    test_cdb_same_cycle();
    test_full_and_wr_err();
    test_hold();
    test_issue_write_same_entry();
    test_flush_and_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
